// File: rtl/relu_requant_int8.sv
// ---------------------------------------------------------------------------
// relu_requant_int8
//
// Streaming requantiser that sits right after the int32 ReLU stage. Each
// accepted activation is multiplied by an unsigned fixed-point scale,
// round-shifted (round half up), offset by a signed zero point and saturated
// to int8. The scale, shift and zero point are captured with the element,
// so a config change only affects elements accepted after it. A
// ROWS x COLS tile index and an end-of-tile flag travel with each element.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cfg_mult              unsigned scale multiplier
//   cfg_shift             arithmetic right shift applied after the multiply
//   cfg_zp                signed int8 output zero point
//   clr_stats             synchronous clear of sat_count
//   in_valid/in_ready     input handshake, in_data is a signed activation
//   out_valid/out_ready   output handshake
//   out_data              signed int8 result
//   out_row/out_col       tile position of out_data
//   out_last              final element of a tile
//   sat_count             number of saturated results delivered (sticky max)
// ---------------------------------------------------------------------------
module relu_requant_int8 #(
    parameter int DATA_W  = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5,
    parameter int ROWS    = 3,
    parameter int COLS    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MULT_W-1:0]  cfg_mult,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [7:0]         cfg_zp,
    input  logic               clr_stats,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic [1:0]         out_row,
    output logic [1:0]         out_col,
    output logic               out_last,
    output logic [15:0]        sat_count
);

    // One extra bit keeps the unsigned multiplier positive in a signed product.
    localparam int PROD_W = DATA_W + MULT_W + 1;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
    localparam logic [1:0] LAST_COL = 2'(COLS - 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-128);

    // Stage 1 registers (product)
    logic                      r_valid1;
    logic signed [PROD_W-1:0]  r_prod1;
    logic [SHIFT_W-1:0]        r_shift1;
    logic [7:0]                r_zp1;
    logic [1:0]                r_row1;
    logic [1:0]                r_col1;

    // Stage 2 registers (rounded value)
    logic                      r_valid2;
    logic signed [PROD_W-1:0]  r_round2;
    logic [7:0]                r_zp2;
    logic [1:0]                r_row2;
    logic [1:0]                r_col2;

    // Stage 3 / output registers
    logic                      r_outValid;
    logic [7:0]                r_outData;
    logic [1:0]                r_outRow;
    logic [1:0]                r_outCol;
    logic                      r_outLast;
    logic                      r_outSat;
    logic [15:0]               r_satCount;

    // Tile index of the next element to be accepted
    logic [1:0]                r_row;
    logic [1:0]                r_col;

    logic                      w_load1;
    logic                      w_load2;
    logic                      w_load3;
    logic                      w_inFire;
    logic                      w_outFire;
    logic signed [PROD_W-1:0]  w_inExt;
    logic signed [PROD_W-1:0]  w_multExt;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [PROD_W-1:0]  w_bias;
    logic signed [PROD_W-1:0]  w_sum;
    logic signed [PROD_W-1:0]  w_round;
    logic signed [SUM_W-1:0]   w_offset;
    logic [7:0]                w_sat8;
    logic                      w_isSat;

    // A stage may load when it is empty or its contents move on this cycle,
    // so a stall ripples back only once every stage is occupied.
    assign w_load3   = !r_outValid || out_ready;
    assign w_load2   = !r_valid2 || w_load3;
    assign w_load1   = !r_valid1 || w_load2;
    assign in_ready  = w_load1;
    assign w_inFire  = in_valid && w_load1;
    assign w_outFire = r_outValid && out_ready;

    assign w_inExt   = {{(PROD_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign w_multExt = {{(PROD_W-MULT_W){1'b0}}, cfg_mult};
    assign w_prod    = w_inExt * w_multExt;

    // Adding half an LSB before the arithmetic shift gives round half up;
    // with a zero shift there is nothing to round.
    assign w_bias  = (r_shift1 == '0) ? '0 : (PROD_W'(1) << (r_shift1 - SHIFT_W'(1)));
    assign w_sum   = r_prod1 + w_bias;
    assign w_round = w_sum >>> r_shift1;

    assign w_offset = {r_round2[PROD_W-1], r_round2} + {{(SUM_W-8){r_zp2[7]}}, r_zp2};

    always_comb begin
        w_sat8  = w_offset[7:0];
        w_isSat = 1'b0;
        if (w_offset > SAT_MAX) begin
            w_sat8  = 8'h7F;
            w_isSat = 1'b1;
        end else if (w_offset < SAT_MIN) begin
            w_sat8  = 8'h80;
            w_isSat = 1'b1;
        end
    end

    // Tile index walks row-major and wraps after the last element of a tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_inFire) begin
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == LAST_ROW) ? 2'd0 : r_row + 2'd1;
            end else begin
                r_col <= r_col + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid1 <= 1'b0;
            r_prod1  <= '0;
            r_shift1 <= '0;
            r_zp1    <= '0;
            r_row1   <= '0;
            r_col1   <= '0;
        end else if (w_load1) begin
            r_valid1 <= in_valid;
            if (in_valid) begin
                r_prod1  <= w_prod;
                r_shift1 <= cfg_shift;
                r_zp1    <= cfg_zp;
                r_row1   <= r_row;
                r_col1   <= r_col;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid2 <= 1'b0;
            r_round2 <= '0;
            r_zp2    <= '0;
            r_row2   <= '0;
            r_col2   <= '0;
        end else if (w_load2) begin
            r_valid2 <= r_valid1;
            if (r_valid1) begin
                r_round2 <= w_round;
                r_zp2    <= r_zp1;
                r_row2   <= r_row1;
                r_col2   <= r_col1;
            end
        end
    end

    // Output registers only change when empty or consumed, so they hold
    // steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outRow   <= '0;
            r_outCol   <= '0;
            r_outLast  <= 1'b0;
            r_outSat   <= 1'b0;
        end else if (w_load3) begin
            r_outValid <= r_valid2;
            if (r_valid2) begin
                r_outData <= w_sat8;
                r_outRow  <= r_row2;
                r_outCol  <= r_col2;
                r_outLast <= (r_row2 == LAST_ROW) && (r_col2 == LAST_COL);
                r_outSat  <= w_isSat;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_satCount <= '0;
        end else if (clr_stats) begin
            r_satCount <= '0;
        end else if (w_outFire && r_outSat && (r_satCount != 16'hFFFF)) begin
            r_satCount <= r_satCount + 16'd1;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_row   = r_outRow;
    assign out_col   = r_outCol;
    assign out_last  = r_outLast;
    assign sat_count = r_satCount;

endmodule

// File: tb/tb_relu_requant_int8.sv
// ---------------------------------------------------------------------------
// tb_relu_requant_int8
//
// Self-checking bench for relu_requant_int8. A monitor records every input
// handshake as an expected item computed by a plain-arithmetic reference
// model, and every output handshake as an observed item. Each scenario task
// drives stimulus and compares observed against expected inline.
// ---------------------------------------------------------------------------
module tb_relu_requant_int8;

    localparam int ROWS = 3;
    localparam int COLS = 4;
    localparam int TILE = ROWS * COLS;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_mult;
    logic [4:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        clr_stats;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic [15:0] sat_count;

    typedef struct {
        logic [7:0] data;
        logic [1:0] row;
        logic [1:0] col;
        logic       last;
        logic       sat;
        int         cyc;
    } item_t;

    item_t expQ[$];
    item_t obsQ[$];
    int    total  = 0;
    int    bad    = 0;
    int    cyc    = 0;
    int    mIdx   = 0;
    int    expSat = 0;
    bit    sendDone;

    always #5 clk = ~clk;

    relu_requant_int8 dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .clr_stats (clr_stats),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .sat_count (sat_count)
    );

    // Reference: exact integer arithmetic, floor division for the shift.
    function automatic item_t model(input logic [31:0] d, input logic [15:0] m,
                                    input logic [4:0] s, input logic [7:0] z,
                                    input int idx, input int c);
        longint p;
        longint r;
        longint v;
        item_t  it;
        p = longint'($signed(d)) * longint'(m);
        if (s == 5'd0) r = p;
        else           r = (p + (longint'(1) << (s - 1))) >>> s;
        v = r + longint'($signed(z));
        it.sat  = (v > 127) || (v < -128);
        it.data = (v > 127) ? 8'h7F : ((v < -128) ? 8'h80 : 8'(v));
        it.row  = 2'(idx / COLS);
        it.col  = 2'(idx % COLS);
        it.last = (idx == TILE - 1);
        it.cyc  = c;
        return it;
    endfunction

    // Samples handshakes between edges and files them at the next rising edge.
    always begin : monitor
        logic        hsIn;
        logic        hsOut;
        logic [31:0] d;
        logic [15:0] m;
        logic [4:0]  s;
        logic [7:0]  z;
        item_t       o;
        @(negedge clk);
        #2;
        hsIn   = (in_valid === 1'b1) && (in_ready === 1'b1);
        hsOut  = (out_valid === 1'b1) && (out_ready === 1'b1);
        d      = in_data;
        m      = cfg_mult;
        s      = cfg_shift;
        z      = cfg_zp;
        o.data = out_data;
        o.row  = out_row;
        o.col  = out_col;
        o.last = out_last;
        o.sat  = 1'b0;
        o.cyc  = 0;
        @(posedge clk);
        cyc++;
        if (rst !== 1'b1) begin
            if (hsIn) begin
                expQ.push_back(model(d, m, s, z, mIdx, cyc));
                mIdx = (mIdx + 1) % TILE;
            end
            if (hsOut) begin
                o.cyc = cyc;
                obsQ.push_back(o);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [15:0] m,
                        input logic [4:0] s, input logic [7:0] z);
        int t;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        cfg_mult  = m;
        cfg_shift = s;
        cfg_zp    = z;
        #1;
        t = 0;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL send_timeout: in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitOut(input int n);
        int t;
        t = 0;
        while (obsQ.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        expQ.delete();
        obsQ.delete();
        mIdx   = 0;
        expSat = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_row !== 2'd0 ||
            out_col !== 2'd0 || out_last !== 1'b0 || sat_count !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%0d r=%0d c=%0d l=%b s=%0d required all 0",
                     out_valid, out_data, out_row, out_col, out_last, sat_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ins[4];
        logic [7:0]  want[4];
        item_t       o;
        item_t       e;
        ins  = '{32'd1000, 32'd24, 32'd23, 32'd0};
        want = '{8'd63, 8'd2, 8'd1, 8'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(ins[i], 16'd1, 5'd4, 8'd0);
        idle();
        waitOut(4);
        total++;
        if (obsQ.size() != 4) begin
            bad++;
            $display("[TB] FAIL basic_count: got %0d required 4", obsQ.size());
        end
        for (int i = 0; i < 4 && obsQ.size() > 0 && expQ.size() > 0; i++) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (o.data !== want[i]) begin
                bad++;
                $display("[TB] FAIL basic_data[%0d]: got %0d required %0d", i, $signed(o.data), $signed(want[i]));
            end
            total++;
            if (o.cyc - e.cyc != 3) begin
                bad++;
                $display("[TB] FAIL basic_latency[%0d]: got %0d required 3", i, o.cyc - e.cyc);
            end
            total++;
            if (o.row !== e.row || o.col !== e.col || o.last !== e.last) begin
                bad++;
                $display("[TB] FAIL basic_index[%0d]: got (%0d,%0d,%b) required (%0d,%0d,%b)",
                         i, o.row, o.col, o.last, e.row, e.col, e.last);
            end
            if (e.sat) expSat++;
        end
        total++;
        if (sat_count !== 16'd0) begin
            bad++;
            $display("[TB] FAIL basic_sat_count: got %0d required 0", sat_count);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] want[3];
        item_t      o;
        item_t      e;
        want = '{8'h7F, 8'h80, 8'hC2};
        out_ready = 1'b1;
        send(32'd1000, 16'd3, 5'd4, 8'd0);
        send(32'd0, 16'd3, 5'd4, 8'h80);
        send(32'(-1000), 16'd1, 5'd4, 8'd0);
        idle();
        waitOut(3);
        total++;
        if (obsQ.size() != 3) begin
            bad++;
            $display("[TB] FAIL sat_count_items: got %0d required 3", obsQ.size());
        end
        for (int i = 0; i < 3 && obsQ.size() > 0 && expQ.size() > 0; i++) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (o.data !== want[i]) begin
                bad++;
                $display("[TB] FAIL sat_data[%0d]: got %0d required %0d", i, $signed(o.data), $signed(want[i]));
            end
        end
        total++;
        if (sat_count !== 16'd1) begin
            bad++;
            $display("[TB] FAIL sat_counter: got %0d required 1", sat_count);
        end
        @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        #1;
        total++;
        if (sat_count !== 16'd0) begin
            bad++;
            $display("[TB] FAIL sat_clear: got %0d required 0", sat_count);
        end
        expSat = 0;
    endtask

    task automatic test_config_change();
        logic [7:0] want[2];
        item_t      o;
        item_t      e;
        want = '{8'd0, 8'd5};
        out_ready = 1'b1;
        send(32'd5, 16'd1, 5'd4, 8'd0);
        send(32'd5, 16'd1, 5'd0, 8'd0);
        idle();
        waitOut(2);
        total++;
        if (obsQ.size() != 2) begin
            bad++;
            $display("[TB] FAIL cfg_count: got %0d required 2", obsQ.size());
        end
        for (int i = 0; i < 2 && obsQ.size() > 0 && expQ.size() > 0; i++) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (o.data !== want[i]) begin
                bad++;
                $display("[TB] FAIL cfg_data[%0d]: got %0d required %0d", i, $signed(o.data), $signed(want[i]));
            end
            if (e.sat) expSat++;
        end
    endtask

    task automatic test_tile_framing();
        item_t o;
        item_t e;
        applyReset();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * TILE; i++)
            send(32'($urandom_range(0, 100000)), 16'($urandom_range(1, 300)),
                 5'($urandom_range(0, 12)), 8'($urandom_range(0, 255)));
        idle();
        waitOut(2 * TILE);
        total++;
        if (obsQ.size() != 2 * TILE) begin
            bad++;
            $display("[TB] FAIL tile_count: got %0d required %0d", obsQ.size(), 2 * TILE);
        end
        for (int i = 0; i < 2 * TILE && obsQ.size() > 0 && expQ.size() > 0; i++) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (o.data !== e.data) begin
                bad++;
                $display("[TB] FAIL tile_data[%0d]: got %0d required %0d", i, $signed(o.data), $signed(e.data));
            end
            total++;
            if (o.row !== 2'((i % TILE) / COLS) || o.col !== 2'(i % COLS) ||
                o.last !== ((i % TILE) == TILE - 1)) begin
                bad++;
                $display("[TB] FAIL tile_index[%0d]: got (%0d,%0d,%b) required (%0d,%0d,%b)", i,
                         o.row, o.col, o.last, (i % TILE) / COLS, i % COLS, (i % TILE) == TILE - 1);
            end
            if (e.sat) expSat++;
        end
        total++;
        if (sat_count !== 16'(expSat)) begin
            bad++;
            $display("[TB] FAIL tile_sat_count: got %0d required %0d", sat_count, expSat);
        end
    endtask

    task automatic test_backpressure();
        item_t o;
        item_t e;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send(32'($urandom_range(0, 50000)), 16'($urandom_range(1, 64)),
                         5'($urandom_range(0, 10)), 8'($urandom_range(0, 255)));
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    #1;
                    total++;
                    if (in_ready !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL bp_in_ready[%0d]: got %b required 0", k, in_ready);
                    end
                    total++;
                    if (expQ.size() - obsQ.size() != 3) begin
                        bad++;
                        $display("[TB] FAIL bp_inflight[%0d]: got %0d required 3", k, expQ.size() - obsQ.size());
                    end
                    if (obsQ.size() < expQ.size()) begin
                        total++;
                        if (out_valid !== 1'b1 || out_data !== expQ[obsQ.size()].data) begin
                            bad++;
                            $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%0d required v=1 d=%0d", k,
                                     out_valid, $signed(out_data), $signed(expQ[obsQ.size()].data));
                        end
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        waitOut(20);
        total++;
        if (obsQ.size() != 20) begin
            bad++;
            $display("[TB] FAIL bp_count: got %0d required 20", obsQ.size());
        end
        for (int i = 0; i < 20 && obsQ.size() > 0 && expQ.size() > 0; i++) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (o.data !== e.data || o.row !== e.row || o.col !== e.col || o.last !== e.last) begin
                bad++;
                $display("[TB] FAIL bp_item[%0d]: got (%0d,%0d,%0d,%b) required (%0d,%0d,%0d,%b)", i,
                         $signed(o.data), o.row, o.col, o.last, $signed(e.data), e.row, e.col, e.last);
            end
            if (e.sat) expSat++;
        end
    endtask

    task automatic test_reset_midstream();
        item_t o;
        item_t e;
        out_ready = 1'b1;
        send(32'd1000, 16'd3, 5'd4, 8'd0);
        idle();
        waitOut(1);
        if (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            if (e.sat) expSat++;
            total++;
            if (o.data !== 8'h7F) begin
                bad++;
                $display("[TB] FAIL mid_pre_data: got %0d required 127", $signed(o.data));
            end
        end
        total++;
        if (sat_count !== 16'(expSat)) begin
            bad++;
            $display("[TB] FAIL mid_pre_sat: got %0d required %0d", sat_count, expSat);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'd4000, 16'd5, 5'd2, 8'd0);
        idle();
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || expQ.size() != 3) begin
            bad++;
            $display("[TB] FAIL mid_inflight: got v=%b n=%0d required v=1 n=3", out_valid, expQ.size());
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || sat_count !== 16'd0) begin
            bad++;
            $display("[TB] FAIL mid_async: got v=%b s=%0d required v=0 s=0", out_valid, sat_count);
        end
        expQ.delete();
        obsQ.delete();
        mIdx   = 0;
        expSat = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'd24, 16'd1, 5'd4, 8'd0);
        idle();
        waitOut(1);
        total++;
        if (obsQ.size() != 1) begin
            bad++;
            $display("[TB] FAIL mid_post_count: got %0d required 1", obsQ.size());
        end
        if (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (o.data !== 8'd2 || o.row !== 2'd0 || o.col !== 2'd0) begin
                bad++;
                $display("[TB] FAIL mid_post_item: got (%0d,%0d,%0d) required (2,0,0)",
                         $signed(o.data), o.row, o.col);
            end
        end
    endtask

    task automatic test_random();
        item_t       o;
        item_t       e;
        logic [31:0] d;
        sendDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    case ($urandom_range(0, 2))
                        0:       d = 32'($urandom_range(0, 4095));
                        1:       d = $urandom;
                        default: d = 32'(-$signed(32'($urandom_range(0, 100000))));
                    endcase
                    if ($urandom_range(0, 3) == 0) idle();
                    send(d, 16'($urandom_range(0, 65535)), 5'($urandom_range(0, 31)),
                         8'($urandom_range(0, 255)));
                end
                idle();
                sendDone = 1'b1;
            end
            begin
                while (!sendDone) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        waitOut(80);
        total++;
        if (obsQ.size() != 80) begin
            bad++;
            $display("[TB] FAIL rand_count: got %0d required 80", obsQ.size());
        end
        for (int i = 0; i < 80 && obsQ.size() > 0 && expQ.size() > 0; i++) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            total++;
            if (o.data !== e.data || o.row !== e.row || o.col !== e.col || o.last !== e.last) begin
                bad++;
                $display("[TB] FAIL rand_item[%0d]: got (%0d,%0d,%0d,%b) required (%0d,%0d,%0d,%b)", i,
                         $signed(o.data), o.row, o.col, o.last, $signed(e.data), e.row, e.col, e.last);
            end
            if (e.sat) expSat++;
        end
        total++;
        if (sat_count !== 16'(expSat)) begin
            bad++;
            $display("[TB] FAIL rand_sat_count: got %0d required %0d", sat_count, expSat);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_mult  = 16'd1;
        cfg_shift = 5'd0;
        cfg_zp    = 8'd0;
        clr_stats = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_saturation();
        test_config_change();
        test_tile_framing();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/relu_requant_int8.md
Name: relu_requant_int8

Overview:
- Streaming requantiser directly downstream of the int32 ReLU stage in the KWS datapath.
- Takes rectified int32 activations one element per handshake, in row-major order over a ROWS x COLS tile.
- Per element: multiply by a fixed-point scale, round-shift, add a zero point, saturate to int8.
- Outputs carry tile row/col indices and an end-of-tile flag for the next layer's input buffer.

Parameters:
- DATA_W, 32, input activation width (signed).
- MULT_W, 16, unsigned scale multiplier width.
- SHIFT_W, 5, right-shift amount width (shift 0..31).
- ROWS, 3, tile rows.
- COLS, 4, tile columns.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_mult  in  MULT_W  unsigned scale multiplier.
- cfg_shift  in  SHIFT_W  arithmetic right shift after multiply.
- cfg_zp  in  8  signed output zero point.
- clr_stats  in  1  synchronous clear of sat_count.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  DATA_W  signed activation.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  signed int8 result.
- out_row  out  2  row index of out_data (0..ROWS-1).
- out_col  out  2  column index of out_data (0..COLS-1).
- out_last  out  1  high with the final element of a tile (row ROWS-1, col COLS-1).
- sat_count  out  16  count of saturated outputs delivered.

Behaviour:
- Reset (async, rst=1): every stage valid = 0; out_valid = 0; out_data = 0; out_row = 0; out_col = 0; out_last = 0; sat_count = 0; index counter = (0,0). in_ready = 1 immediately after reset is released.
- Accept: input handshake is in_valid && in_ready. Output handshake is out_valid && out_ready.
- Config capture: cfg_mult, cfg_shift and cfg_zp are sampled at the input handshake and carried down the pipeline with the element. A config change mid-stream affects only elements accepted afterwards.
- Pipeline S1 (multiply): prod = in_data * {1'b0,cfg_mult}, signed, 49 bits, no overflow possible.
- Pipeline S2 (round-shift):
  - shift = 0: r = prod.
  - Otherwise: r = (prod + 2^(shift-1)) >>> shift, arithmetic shift, 49-bit.
  - This is round-half-up (toward +inf); negative inputs are handled even though ReLU should not produce them.
- Pipeline S3 (offset, saturate): v = r + sign-extended cfg_zp.
  - out_data = 127 if v > 127; -128 if v < -128; else v[7:0].
  - The sat flag is set when clamping occurred.
- Latency: 3 cycles from input handshake to out_valid, with out_ready held high. Throughput is 1 element/cycle.
- Per-stage flow control: a stage loads when it is empty or its successor loads (or, for S3, when out_ready is high).
  - in_ready = (S1 empty) || S1 loads.
  - Bubbles collapse: after a stall, up to 3 elements are held. No element is dropped or duplicated.
  - in_ready is combinational from out_ready.
- Output registers hold stable while out_valid && !out_ready.
- Index counter: on each input handshake, col increments. At col = COLS-1, col wraps to 0 and row increments. At row = ROWS-1, col = COLS-1, both wrap to 0.
  - (row, col) travel with the element. out_last = (row==ROWS-1 && col==COLS-1).
- sat_count: increments by 1 on each output handshake whose element saturated. It sticks at 16'hFFFF.
  - clr_stats=1 sets it to 0 next cycle. clr_stats takes priority over a simultaneous increment.
- Reset mid-operation discards all in-flight elements and restarts the index at (0,0).

Test Plan:
- Basic: reset, cfg_mult=1, cfg_shift=4, cfg_zp=0; stream 1000, 24, 23, 0 -> out_data 63, 2, 1, 0, each 3 cycles after acceptance; sat_count stays 0.
- Saturation: cfg_mult=3, cfg_shift=4, in 1000 -> 127, sat_count=1. Then cfg_zp=-128, in 0 -> -128, no saturation. Then in -1000 with mult=1, shift=4, zp=0 -> -62.
- Tile framing: stream 24 elements back-to-back -> out_row/out_col sequence (0,0),(0,1)..(2,3) twice; out_last high only on the 12th and 24th outputs.
- Backpressure: out_ready low for 10 cycles during a continuous stream -> in_ready falls after 3 elements are buffered. After release, outputs are in order with no loss or duplication, and out_data stays stable while stalled.
- Config change mid-stream: switch cfg_shift from 4 to 0 between two accepted elements of value 5 (mult=1) -> outputs 0 then 5.
- Async reset mid-stream with 3 elements in flight -> out_valid=0 and sat_count=0 at once. The first element after reset exits with index (0,0).
